// File: rtl/store_align_unit_pkg.sv
// ---------------------------------------------------------------------------
// store_align_unit_pkg
//   Shared definitions for the store alignment path:
//   - store_op_e : store size codes carried on req_op
//   - state_e    : beat sequencer states of store_align_unit
// ---------------------------------------------------------------------------
package store_align_unit_pkg;

    typedef enum logic [1:0] {
        OP_W   = 2'b00,  // full bus word
        OP_H   = 2'b01,  // half word, 2 bytes
        OP_B   = 2'b10,  // single byte
        OP_RSV = 2'b11   // reserved, always faults
    } store_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT0 = 2'b01,
        S_BEAT1 = 2'b10
    } state_e;

endpackage

// File: rtl/store_align_unit_be_gen.sv
// ---------------------------------------------------------------------------
// store_align_unit_be_gen
//   Combinational decode of one store request into a two-word-wide view.
//   The lower half of mask/data is the first bus beat; the upper half is the
//   spill-over beat used only when the store crosses a bus word.
// Ports
//   op         in   2          store size code (store_op_e)
//   off        in   OFF_W      byte offset of the store inside the bus word
//   wdata      in   DATA_W     right-justified store datum
//   mask       out  2*BYTES    byte enables over two consecutive bus words
//   data       out  2*DATA_W   datum shifted into its byte lanes
//   misaligned out  1          offset is not a multiple of the store size
//   crossing   out  1          store spills into the next bus word
// ---------------------------------------------------------------------------
module store_align_unit_be_gen
    import store_align_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(BYTES)
) (
    input  logic [1:0]          op,
    input  logic [OFF_W-1:0]    off,
    input  logic [DATA_W-1:0]   wdata,
    output logic [2*BYTES-1:0]  mask,
    output logic [2*DATA_W-1:0] data,
    output logic                misaligned,
    output logic                crossing
);

    // Two extra bits so that off + size never overflows
    localparam int SZ_W = OFF_W + 2;
    localparam logic [SZ_W-1:0] SZ_FULL = SZ_W'(BYTES);
    localparam logic [SZ_W-1:0] SZ_HALF = SZ_W'(2'd2);
    localparam logic [SZ_W-1:0] SZ_BYTE = SZ_W'(1'd1);

    logic [2*BYTES-1:0] unit_mask_s;
    logic [SZ_W-1:0]    size_s;

    // Size decode: unshifted enable pattern, byte count and alignment test
    always_comb begin
        unit_mask_s = {(2*BYTES){1'b0}};
        size_s      = SZ_BYTE;
        misaligned  = 1'b0;
        case (op)
            OP_W: begin
                unit_mask_s[BYTES-1:0] = {BYTES{1'b1}};
                size_s                 = SZ_FULL;
                misaligned             = |off;
            end
            OP_H: begin
                unit_mask_s[1:0] = 2'b11;
                size_s           = SZ_HALF;
                misaligned       = off[0];
            end
            OP_B: begin
                unit_mask_s[0] = 1'b1;
                size_s         = SZ_BYTE;
                misaligned     = 1'b0;
            end
            default: begin
                // Reserved op: no lanes enabled, the top level faults it
                unit_mask_s = {(2*BYTES){1'b0}};
                size_s      = SZ_BYTE;
                misaligned  = 1'b0;
            end
        endcase
    end

    assign mask     = unit_mask_s << off;
    assign data     = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    assign crossing = ({2'b00, off} + size_s) > SZ_FULL;

endmodule

// File: rtl/store_align_unit.sv
// ---------------------------------------------------------------------------
// store_align_unit
//   Store path between the MEM stage and the data-memory bus. Accepts one
//   store per req handshake and issues one or two registered bus beats with
//   byte enables and lane-aligned data. Stores crossing a bus word are split
//   into two back-to-back beats when ALLOW_MISALIGN=1; misaligned stores with
//   ALLOW_MISALIGN=0 and reserved ops raise a one-cycle AdES pulse instead.
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready is a combinational decode)
//   req_op/addr/wdata   store size code, byte address, right-justified data
//   mem_valid/ready     bus beat handshake
//   mem_addr/be/wdata   word-aligned address, byte enables, lane data
//   exc_valid/exc_addr  AdES pulse and the faulting address (held)
//   busy                a beat is pending
// ---------------------------------------------------------------------------
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                exc_valid,
    output logic [ADDR_W-1:0]   exc_addr,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES);

    // Request decode
    logic [OFF_W-1:0]    off_s;
    logic [2*BYTES-1:0]  mask_s;
    logic [2*DATA_W-1:0] data_s;
    logic                misaligned_s;
    logic                crossing_s;
    logic                exc_s;
    logic                last_beat_s;
    logic                accept_s;
    logic                load_s;
    logic [ADDR_W-1:0]   beat0_addr_s;
    logic [ADDR_W-1:0]   beat1_addr_s;

    // Sequencer and output registers
    state_e              state_r;
    logic                cross_r;
    logic                busy_r;
    logic                mem_valid_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [BYTES-1:0]    mem_be_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [ADDR_W-1:0]   b1_addr_r;
    logic [BYTES-1:0]    b1_be_r;
    logic [DATA_W-1:0]   b1_wdata_r;
    logic                exc_valid_r;
    logic [ADDR_W-1:0]   exc_addr_r;

    assign off_s = req_addr[OFF_W-1:0];

    store_align_unit_be_gen #(
        .DATA_W (DATA_W)
    ) u_be_gen (
        .op         (req_op),
        .off        (off_s),
        .wdata      (req_wdata),
        .mask       (mask_s),
        .data       (data_s),
        .misaligned (misaligned_s),
        .crossing   (crossing_s)
    );

    // A crossing store is always misaligned, so with ALLOW_MISALIGN=0 it
    // never reaches the sequencer.
    assign exc_s = (req_op == OP_RSV) | (misaligned_s & ~ALLOW_MISALIGN);

    // The beat on the bus is the last one of its store: BEAT1, or BEAT0 of a
    // store that does not cross.
    assign last_beat_s = (state_r == S_BEAT1) | ((state_r == S_BEAT0) & ~cross_r);
    assign req_ready   = (state_r == S_IDLE) | (last_beat_s & mem_valid_r & mem_ready);
    assign accept_s    = req_valid & req_ready;
    assign load_s      = accept_s & ~exc_s;

    assign beat0_addr_s = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat1_addr_s = beat0_addr_s + WORD_STEP;

    // Beat sequencer, beat-1 holding register and exception capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cross_r     <= 1'b0;
            busy_r      <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_be_r    <= {BYTES{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            b1_addr_r   <= {ADDR_W{1'b0}};
            b1_be_r     <= {BYTES{1'b0}};
            b1_wdata_r  <= {DATA_W{1'b0}};
            exc_valid_r <= 1'b0;
            exc_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            exc_valid_r <= accept_s & exc_s;
            if (accept_s & exc_s) begin
                exc_addr_r <= req_addr;
            end

            // load_s is only possible from IDLE or on the last-beat handshake,
            // so it takes priority over the per-state transitions.
            if (load_s) begin
                state_r     <= S_BEAT0;
                busy_r      <= 1'b1;
                mem_valid_r <= 1'b1;
                mem_addr_r  <= beat0_addr_s;
                mem_be_r    <= mask_s[BYTES-1:0];
                mem_wdata_r <= data_s[DATA_W-1:0];
                cross_r     <= crossing_s;
                b1_addr_r   <= beat1_addr_s;
                b1_be_r     <= mask_s[2*BYTES-1:BYTES];
                b1_wdata_r  <= data_s[2*DATA_W-1:DATA_W];
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_BEAT0: begin
                        if (mem_ready) begin
                            if (cross_r) begin
                                state_r     <= S_BEAT1;
                                mem_addr_r  <= b1_addr_r;
                                mem_be_r    <= b1_be_r;
                                mem_wdata_r <= b1_wdata_r;
                            end else begin
                                state_r     <= S_IDLE;
                                busy_r      <= 1'b0;
                                mem_valid_r <= 1'b0;
                            end
                        end
                    end
                    S_BEAT1: begin
                        if (mem_ready) begin
                            state_r     <= S_IDLE;
                            busy_r      <= 1'b0;
                            mem_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                        mem_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign exc_valid = exc_valid_r;
    assign exc_addr  = exc_addr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_store_align_unit.sv
// ---------------------------------------------------------------------------
// tb_store_align_unit
//   Runs three configurations side by side: 32-bit strict, 32-bit split and
//   64-bit split. Each has its own reference model that expands an accepted
//   store byte by byte into the bus beats it must produce.
// ---------------------------------------------------------------------------
module tb_store_align_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
    } beat_t;

    localparam int NDIR = 11;
    localparam logic [1:0]  DOP   [NDIR] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1, 2'd0,
                                             2'd2, 2'd2, 2'd2, 2'd2};
    localparam logic [31:0] DADDR [NDIR] = '{32'h1000, 32'h1003, 32'h1002, 32'h1001,
                                             32'h1000, 32'h1003, 32'h2006, 32'h2000,
                                             32'h2001, 32'h2002, 32'h2003};
    localparam logic [63:0] DDATA [NDIR] = '{64'hDEAD_BEEF, 64'hAB, 64'hBEEF, 64'hBEEF,
                                             64'h1234_5678, 64'hBEEF, 64'h0123_4567_89AB_CDEF,
                                             64'h11, 64'h22, 64'h33, 64'h44};

    logic clk;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW = (g == 2) ? 64 : 32;
        localparam int B  = DW / 8;
        localparam bit AM = (g != 0);

        logic          rst;
        logic          req_valid;
        logic          req_ready;
        logic [1:0]    req_op;
        logic [31:0]   req_addr;
        logic [DW-1:0] req_wdata;
        logic          mem_valid;
        logic          mem_ready;
        logic [31:0]   mem_addr;
        logic [B-1:0]  mem_be;
        logic [DW-1:0] mem_wdata;
        logic          exc_valid;
        logic [31:0]   exc_addr;
        logic          busy;

        beat_t       q[$];
        logic        exp_exc;
        logic [31:0] exp_eaddr;
        bit          fin;

        store_align_unit #(
            .DATA_W         (DW),
            .ADDR_W         (32),
            .ALLOW_MISALIGN (AM)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_op    (req_op),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .mem_valid (mem_valid),
            .mem_ready (mem_ready),
            .mem_addr  (mem_addr),
            .mem_be    (mem_be),
            .mem_wdata (mem_wdata),
            .exc_valid (exc_valid),
            .exc_addr  (exc_addr),
            .busy      (busy)
        );

        function automatic string tg(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        function automatic int size_of(input logic [1:0] op);
            return (op == 2'd0) ? B : ((op == 2'd1) ? 2 : 1);
        endfunction

        function automatic bit raises(input logic [1:0] op, input logic [31:0] addr);
            int off;
            off = int'(addr % 32'(B));
            return (op == 2'd3) || (((off % size_of(op)) != 0) && !AM);
        endfunction

        // Expand a store into the beats it touches, one byte at a time.
        task automatic push_store(input logic [1:0] op, input logic [31:0] addr,
                                  input logic [63:0] wd);
            int    n;
            int    off;
            int    nb;
            int    s;
            beat_t b;
            n   = size_of(op);
            off = int'(addr % 32'(B));
            nb  = (off + n > B) ? 2 : 1;
            for (int j = 0; j < nb; j++) begin
                b.addr = addr - 32'(off) + 32'(j * B);
                b.be   = 8'h00;
                b.wd   = 64'h0;
                for (int l = 0; l < B; l++) begin
                    s = j * B + l - off;
                    if (s >= 0 && s < B) b.wd[8*l +: 8] = wd[8*s +: 8];
                    if (s >= 0 && s < n) b.be[l] = 1'b1;
                end
                q.push_back(b);
            end
        endtask

        task automatic reset_checks(input string w);
            check_eq(tg({w, "_mem_valid"}), mem_valid, 64'd0);
            check_eq(tg({w, "_mem_addr"}),  mem_addr,  64'd0);
            check_eq(tg({w, "_mem_be"}),    mem_be,    64'd0);
            check_eq(tg({w, "_mem_wdata"}), mem_wdata, 64'd0);
            check_eq(tg({w, "_exc_valid"}), exc_valid, 64'd0);
            check_eq(tg({w, "_exc_addr"}),  exc_addr,  64'd0);
            check_eq(tg({w, "_busy"}),      busy,      64'd0);
        endtask

        // One clock: drive at negedge, compare just after, advance the model
        // at the posedge.
        task automatic cyc(input bit v, input logic [1:0] op, input logic [31:0] addr,
                           input logic [63:0] wd, input bit mr, output bit acc);
            bit    er;
            beat_t b;
            @(negedge clk);
            req_valid = v;
            req_op    = op;
            req_addr  = addr;
            req_wdata = wd[DW-1:0];
            mem_ready = mr;
            #1;
            er = (q.size() == 0) || (q.size() == 1 && mr);
            check_eq(tg("req_ready"), req_ready, er);
            check_eq(tg("mem_valid"), mem_valid, q.size() != 0);
            check_eq(tg("busy"),      busy,      q.size() != 0);
            if (q.size() != 0) begin
                check_eq(tg("mem_addr"),  mem_addr,  q[0].addr);
                check_eq(tg("mem_be"),    mem_be,    q[0].be);
                check_eq(tg("mem_wdata"), mem_wdata, q[0].wd);
            end
            check_eq(tg("exc_valid"), exc_valid, exp_exc);
            check_eq(tg("exc_addr"),  exc_addr,  exp_eaddr);
            @(posedge clk);
            if (q.size() != 0 && mr) b = q.pop_front();
            acc     = v && er;
            exp_exc = 1'b0;
            if (acc) begin
                if (raises(op, addr)) begin
                    exp_exc   = 1'b1;
                    exp_eaddr = addr;
                end else begin
                    push_store(op, addr, wd);
                end
            end
        endtask

        initial begin
            bit          acc;
            logic [1:0]  rop;
            logic [31:0] raddr;
            rst       = 1'b0;
            req_valid = 1'b0;
            req_op    = 2'd0;
            req_addr  = 32'h0;
            req_wdata = '0;
            mem_ready = 1'b0;
            exp_exc   = 1'b0;
            exp_eaddr = 32'h0;
            @(negedge clk);
            #1;
            reset_checks("por");
            rst = 1'b1;

            // Directed stores, each held until accepted
            for (int k = 0; k < NDIR; k++) begin
                acc = 1'b0;
                for (int t = 0; t < 8 && !acc; t++)
                    cyc(1'b1, DOP[k], DADDR[k], DDATA[k], 1'b1, acc);
            end
            repeat (3) cyc(1'b0, 2'd0, 32'h0, 64'h0, 1'b1, acc);

            // Backpressure: bus stalls for three cycles on the first beat
            for (int k = 0; k < 2; k++) begin
                cyc(1'b1, 2'd0, 32'h4000 + 32'(2 * k), 64'h0000_0000_CAFE_F00D, 1'b0, acc);
                repeat (3) cyc(1'b0, 2'd0, 32'h0, 64'h0, 1'b0, acc);
                repeat (2) cyc(1'b0, 2'd0, 32'h0, 64'h0, 1'b1, acc);
            end
            repeat (2) cyc(1'b0, 2'd0, 32'h0, 64'h0, 1'b1, acc);

            // Reset with a beat pending (BEAT1 of a split store where allowed)
            cyc(1'b1, 2'd0, 32'h3000 | 32'(AM), 64'h5555_6666_7777_8888, 1'b0, acc);
            cyc(1'b0, 2'd0, 32'h0, 64'h0, AM, acc);
            @(negedge clk);
            #1;
            check_eq(tg("pre_rst_valid"), mem_valid, 64'd1);
            #1;
            rst = 1'b0;
            #1;
            reset_checks("mid");
            q.delete();
            exp_exc   = 1'b0;
            exp_eaddr = 32'h0;
            @(negedge clk);
            rst = 1'b1;

            // Random traffic with random bus stalls
            for (int i = 0; i < 500; i++) begin
                rop = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0:       raddr = $urandom;
                    1:       raddr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                    default: raddr = 32'h1000 + 32'($urandom_range(0, 31));
                endcase
                cyc($urandom_range(0, 99) < 70, rop, raddr, {$urandom, $urandom},
                    $urandom_range(0, 99) < 75, acc);
            end
            repeat (4) cyc(1'b0, 2'd0, 32'h0, 64'h0, 1'b1, acc);
            fin = 1'b1;
        end
    end

    initial begin
        int cycles;
        cycles = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cycles < 20000) begin
            @(posedge clk);
            cycles = cycles + 1;
        end
        check_eq("all_cfg_done", {63'd0, cfg[0].fin & cfg[1].fin & cfg[2].fin}, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
